// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command sequencer.
// Opcodes, FSM states, CFG byte layout and legal oversampling ratios.
package uart_cmd_pkg;

    localparam logic [7:0] OP_WR  = 8'hAA;
    localparam logic [7:0] OP_RD  = 8'hBB;
    localparam logic [7:0] OP_CFG = 8'hCC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_TX_SEND,
        ST_CFG_DATA
    } state_t;

    localparam int CFG_TYP_BIT = 7;
    localparam int CFG_EN_BIT  = 6;
    localparam int CFG_PS_MSB  = 5;
    localparam int CFG_PS_LSB  = 0;

    localparam logic [5:0] PS_8  = 6'd8;
    localparam logic [5:0] PS_16 = 6'd16;
    localparam logic [5:0] PS_32 = 6'd32;

    function automatic logic ps_legal(input logic [5:0] ps);
        return (ps == PS_8) || (ps == PS_16) || (ps == PS_32);
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inactivity counter: cleared on demand, counts while enabled,
// flags the terminal count while enabled.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    assign tc = en && (cnt == TC_VAL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer between the UART receiver and the register file.
// Decodes write/read/config frames and returns read data to the transmitter.
module uart_rx_cmd_ctrl #(
    parameter int ADDR_W       = 4,
    parameter int TIMEOUT_CYC  = 4096,
    parameter int RST_PRESCALE = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic              RX_PAR_ERR,
    input  logic              RX_STP_ERR,
    output logic [ADDR_W-1:0] RF_ADDR,
    output logic              RF_WR_EN,
    output logic [7:0]        RF_WR_DATA,
    output logic              RF_RD_EN,
    input  logic [7:0]        RF_RD_DATA,
    input  logic              RF_RD_VLD,
    output logic [7:0]        TX_P_DATA,
    output logic              TX_D_VLD,
    input  logic              TX_BUSY,
    output logic [5:0]        CFG_PRESCALE,
    output logic              CFG_PAR_EN,
    output logic              CFG_PAR_TYP,
    output logic [7:0]        ERR_CNT
);

    import uart_cmd_pkg::*;

    state_t state, state_nxt;

    logic rx_err, rx_ok, addr_ok, ps_ok;
    logic is_wr, is_rd, is_cfg;
    logic timed, tmo_tc, tmo_clr;
    logic err_inc, addr_ld, wr_go, rd_go, cfg_ld, txd_ld;

    assign rx_err  = RX_PAR_ERR | RX_STP_ERR;
    assign rx_ok   = RX_D_VLD & ~rx_err;
    assign addr_ok = (RX_P_DATA >> ADDR_W) == 8'd0;
    assign ps_ok   = ps_legal(RX_P_DATA[CFG_PS_MSB:CFG_PS_LSB]);
    assign is_wr   = RX_P_DATA == OP_WR;
    assign is_rd   = RX_P_DATA == OP_RD;
    assign is_cfg  = RX_P_DATA == OP_CFG;

    assign timed = (state == ST_WR_ADDR) || (state == ST_WR_DATA) ||
                   (state == ST_RD_ADDR) || (state == ST_RD_WAIT) ||
                   (state == ST_CFG_DATA);

    // Every accepted byte in a timed state also changes state.
    assign tmo_clr = state_nxt != state;

    uart_cmd_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk  (CLK),
        .rst_n(RST),
        .clr  (tmo_clr),
        .en   (timed),
        .tc   (tmo_tc)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (rx_err) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (rx_ok) begin
                        unique case (1'b1)
                            is_wr:   state_nxt = ST_WR_ADDR;
                            is_rd:   state_nxt = ST_RD_ADDR;
                            is_cfg:  state_nxt = ST_CFG_DATA;
                            default: state_nxt = ST_IDLE;
                        endcase
                    end
                end
                ST_WR_ADDR: begin
                    if (rx_ok) state_nxt = addr_ok ? ST_WR_DATA : ST_IDLE;
                    else if (tmo_tc) state_nxt = ST_IDLE;
                end
                ST_WR_DATA: begin
                    if (rx_ok || tmo_tc) state_nxt = ST_IDLE;
                end
                ST_RD_ADDR: begin
                    if (rx_ok) state_nxt = addr_ok ? ST_RD_WAIT : ST_IDLE;
                    else if (tmo_tc) state_nxt = ST_IDLE;
                end
                ST_RD_WAIT: begin
                    if (RF_RD_VLD) state_nxt = ST_TX_SEND;
                    else if (tmo_tc) state_nxt = ST_IDLE;
                end
                ST_TX_SEND: begin
                    if (!TX_BUSY) state_nxt = ST_IDLE;
                end
                ST_CFG_DATA: begin
                    if (rx_ok || tmo_tc) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        err_inc  = rx_err;
        addr_ld  = 1'b0;
        wr_go    = 1'b0;
        rd_go    = 1'b0;
        cfg_ld   = 1'b0;
        txd_ld   = 1'b0;
        TX_D_VLD = 1'b0;
        unique case (state)
            ST_IDLE: begin
                err_inc = rx_err | (rx_ok & ~(is_wr | is_rd | is_cfg));
            end
            ST_WR_ADDR: begin
                addr_ld = rx_ok & addr_ok;
                err_inc = rx_err | (rx_ok & ~addr_ok) | (tmo_tc & ~rx_ok);
            end
            ST_WR_DATA: begin
                wr_go   = rx_ok;
                err_inc = rx_err | (tmo_tc & ~rx_ok);
            end
            ST_RD_ADDR: begin
                addr_ld = rx_ok & addr_ok;
                rd_go   = rx_ok & addr_ok;
                err_inc = rx_err | (rx_ok & ~addr_ok) | (tmo_tc & ~rx_ok);
            end
            ST_RD_WAIT: begin
                txd_ld  = RF_RD_VLD & ~rx_err;
                err_inc = rx_err | (tmo_tc & ~RF_RD_VLD);
            end
            ST_TX_SEND: begin
                TX_D_VLD = ~TX_BUSY;
            end
            ST_CFG_DATA: begin
                cfg_ld  = rx_ok & ps_ok;
                err_inc = rx_err | (rx_ok & ~ps_ok) | (tmo_tc & ~rx_ok);
            end
            default: begin
                err_inc = rx_err;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            RF_ADDR      <= '0;
            RF_WR_EN     <= 1'b0;
            RF_WR_DATA   <= 8'd0;
            RF_RD_EN     <= 1'b0;
            TX_P_DATA    <= 8'd0;
            CFG_PRESCALE <= 6'(RST_PRESCALE);
            CFG_PAR_EN   <= 1'b0;
            CFG_PAR_TYP  <= 1'b0;
            ERR_CNT      <= 8'd0;
        end else begin
            RF_WR_EN <= wr_go;
            RF_RD_EN <= rd_go;
            if (addr_ld) RF_ADDR <= RX_P_DATA[ADDR_W-1:0];
            if (wr_go) RF_WR_DATA <= RX_P_DATA;
            if (txd_ld) TX_P_DATA <= RF_RD_DATA;
            if (cfg_ld) begin
                CFG_PRESCALE <= RX_P_DATA[CFG_PS_MSB:CFG_PS_LSB];
                CFG_PAR_EN   <= RX_P_DATA[CFG_EN_BIT];
                CFG_PAR_TYP  <= RX_P_DATA[CFG_TYP_BIT];
            end
            if (err_inc && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: frame-level reference model compared
// every cycle, plus directed literal checks.
module tb_uart_rx_cmd_ctrl;

    localparam int ADDR_W = 4;
    localparam int TMO    = 64;

    logic              CLK = 1'b0;
    logic              RST;
    logic [7:0]        RX_P_DATA;
    logic              RX_D_VLD, RX_PAR_ERR, RX_STP_ERR;
    logic [ADDR_W-1:0] RF_ADDR;
    logic              RF_WR_EN, RF_RD_EN;
    logic [7:0]        RF_WR_DATA, RF_RD_DATA;
    logic              RF_RD_VLD;
    logic [7:0]        TX_P_DATA;
    logic              TX_D_VLD, TX_BUSY;
    logic [5:0]        CFG_PRESCALE;
    logic              CFG_PAR_EN, CFG_PAR_TYP;
    logic [7:0]        ERR_CNT;

    uart_rx_cmd_ctrl #(
        .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO), .RST_PRESCALE(8)
    ) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RX_PAR_ERR(RX_PAR_ERR), .RX_STP_ERR(RX_STP_ERR),
        .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA),
        .RF_RD_EN(RF_RD_EN), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
        .CFG_PRESCALE(CFG_PRESCALE), .CFG_PAR_EN(CFG_PAR_EN),
        .CFG_PAR_TYP(CFG_PAR_TYP), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int vec = 0;
    int miss = 0;
    int tx_seen = 0;
    bit chk_on = 0;

    // frame-level model
    int       m_err;
    bit [5:0] m_ps;
    bit       m_en, m_typ;
    bit [7:0] fq[$];
    bit       m_rdw, m_txp;
    int       quiet;
    bit       e_wr, e_rd;
    bit [3:0] e_addr;
    bit [7:0] e_wdata, e_txd;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sat(input int v);
        return (v > 255) ? 8'hFF : v[7:0];
    endfunction

    task automatic frame_byte(input bit [7:0] d);
        fq.push_back(d);
        if (!(fq[0] inside {8'hAA, 8'hBB, 8'hCC})) begin
            m_err++;
            fq.delete();
        end else if (fq.size() == 2) begin
            if (fq[0] == 8'hCC) begin
                if (int'(d[5:0]) inside {8, 16, 32}) {m_typ, m_en, m_ps} = d;
                else m_err++;
                fq.delete();
            end else if (int'(d) >= (1 << ADDR_W)) begin
                m_err++;
                fq.delete();
            end else if (fq[0] == 8'hBB) begin
                e_rd = 1; e_addr = d[3:0];
                m_rdw = 1; quiet = 0;
                fq.delete();
            end
        end else if (fq.size() == 3) begin
            e_wr = 1; e_addr = fq[1][3:0]; e_wdata = d;
            fq.delete();
        end
    endtask

    task automatic model(input bit rst, input bit vld, input bit [7:0] d,
                         input bit perr, input bit serr, input bit rdv,
                         input bit [7:0] rdd, input bit busy);
        e_wr = 0; e_rd = 0;
        if (!rst) begin
            m_err = 0; m_ps = 6'd8; m_en = 0; m_typ = 0;
            fq.delete(); m_rdw = 0; m_txp = 0; quiet = 0;
        end else if (perr || serr) begin
            m_err++; fq.delete(); m_rdw = 0; m_txp = 0;
        end else if (m_txp) begin
            if (!busy) m_txp = 0;
        end else if (m_rdw) begin
            if (rdv) begin
                m_rdw = 0; m_txp = 1; e_txd = rdd;
            end else begin
                quiet++;
                if (quiet == TMO) begin m_err++; m_rdw = 0; end
            end
        end else if (vld) begin
            quiet = 0;
            frame_byte(d);
        end else if (fq.size() != 0) begin
            quiet++;
            if (quiet == TMO) begin m_err++; fq.delete(); end
        end
    endtask

    task automatic step();
        bit s_rst, s_vld, s_pe, s_se, s_rdv, s_busy;
        bit [7:0] s_d, s_rdd;
        s_rst = RST; s_vld = RX_D_VLD; s_d = RX_P_DATA;
        s_pe = RX_PAR_ERR; s_se = RX_STP_ERR;
        s_rdv = RF_RD_VLD; s_rdd = RF_RD_DATA; s_busy = TX_BUSY;
        @(posedge CLK);
        #1;
        model(s_rst, s_vld, s_d, s_pe, s_se, s_rdv, s_rdd, s_busy);
        RX_D_VLD = 0; RX_PAR_ERR = 0; RX_STP_ERR = 0; RF_RD_VLD = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input bit [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD = 1;
        step();
    endtask

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("wr_en", RF_WR_EN, e_wr);
            chk("rd_en", RF_RD_EN, e_rd);
            chk("tx_vld", TX_D_VLD, m_txp && !TX_BUSY);
            chk("err_cnt", ERR_CNT, sat(m_err));
            chk("cfg_ps", CFG_PRESCALE, m_ps);
            chk("cfg_en", CFG_PAR_EN, m_en);
            chk("cfg_typ", CFG_PAR_TYP, m_typ);
            if (e_wr || e_rd) chk("rf_addr", RF_ADDR, e_addr);
            if (e_wr) chk("wr_data", RF_WR_DATA, e_wdata);
            if (m_txp) chk("tx_data", TX_P_DATA, e_txd);
            if (TX_D_VLD === 1'b1) tx_seen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        RST = 0; RX_P_DATA = 0; RX_D_VLD = 0; RX_PAR_ERR = 0;
        RX_STP_ERR = 0; RF_RD_DATA = 0; RF_RD_VLD = 0; TX_BUSY = 0;
        step(); step();
        chk("rst_err", ERR_CNT, 8'h00);
        chk("rst_ps", CFG_PRESCALE, 6'd8);
        chk("rst_en", CFG_PAR_EN, 1'b0);
        chk("rst_addr", RF_ADDR, 4'h0);
        chk("rst_wdata", RF_WR_DATA, 8'h00);
        chk("rst_txd", TX_P_DATA, 8'h00);
        chk("rst_wr_en", RF_WR_EN, 1'b0);
        RST = 1;
        chk_on = 1;
        step();

        // write frame
        send(8'hAA); idle(1); send(8'h03); idle(1); send(8'h5C);
        chk("t1_wr_en", RF_WR_EN, 1'b1);
        chk("t1_addr", RF_ADDR, 4'h3);
        chk("t1_data", RF_WR_DATA, 8'h5C);
        idle(2);
        chk("t1_err", ERR_CNT, 8'h00);

        // read with busy transmitter
        TX_BUSY = 1;
        send(8'hBB); send(8'h07);
        chk("t2_rd_en", RF_RD_EN, 1'b1);
        chk("t2_addr", RF_ADDR, 4'h7);
        idle(2);
        RF_RD_DATA = 8'hA5; RF_RD_VLD = 1;
        step();
        t = tx_seen;
        idle(10);
        chk("t2_hold", tx_seen - t, 0);
        TX_BUSY = 0;
        idle(3);
        chk("t2_tx_once", tx_seen - t, 1);
        chk("t2_txd", TX_P_DATA, 8'hA5);

        // config good then bad
        send(8'hCC); send(8'h50);
        chk("t3_ps", CFG_PRESCALE, 6'd16);
        chk("t3_en", CFG_PAR_EN, 1'b1);
        chk("t3_typ", CFG_PAR_TYP, 1'b0);
        idle(1);
        send(8'hCC); send(8'h0C);
        chk("t3_bad_err", ERR_CNT, 8'd1);
        chk("t3_bad_ps", CFG_PRESCALE, 6'd16);

        // error cases
        send(8'hAA); send(8'h03);
        RX_PAR_ERR = 1; send(8'h77);
        chk("t4_par_no_wr", RF_WR_EN, 1'b0);
        chk("t4_par_err", ERR_CNT, 8'd2);
        send(8'h42);
        chk("t4_junk", ERR_CNT, 8'd3);
        send(8'hAA); send(8'h10);
        chk("t4_wr_addr", ERR_CNT, 8'd4);
        send(8'hBB); send(8'h10);
        chk("t4_rd_addr_en", RF_RD_EN, 1'b0);
        chk("t4_rd_addr", ERR_CNT, 8'd5);
        RX_STP_ERR = 1; step();
        chk("t4_stp", ERR_CNT, 8'd6);

        // inactivity timeout at the exact boundary
        send(8'hAA); idle(1); send(8'h02);
        idle(TMO - 1);
        chk("t5_pre_tmo", ERR_CNT, 8'd6);
        idle(1);
        chk("t5_tmo", ERR_CNT, 8'd7);
        send(8'hAA); send(8'h02); send(8'h11);
        chk("t5_wr_en", RF_WR_EN, 1'b1);
        chk("t5_addr", RF_ADDR, 4'h2);
        chk("t5_data", RF_WR_DATA, 8'h11);

        // reset while a read is pending
        send(8'hCC); send(8'hE0);
        chk("t6_ps", CFG_PRESCALE, 6'd32);
        chk("t6_typ", CFG_PAR_TYP, 1'b1);
        send(8'hBB); send(8'h05); idle(2);
        RST = 0; step(); RST = 1;
        chk("t6_rst_ps", CFG_PRESCALE, 6'd8);
        chk("t6_rst_en", CFG_PAR_EN, 1'b0);
        chk("t6_rst_typ", CFG_PAR_TYP, 1'b0);
        chk("t6_rst_err", ERR_CNT, 8'd0);
        t = tx_seen;
        RF_RD_DATA = 8'h5A; RF_RD_VLD = 1; step();
        idle(10);
        chk("t6_no_tx", tx_seen - t, 0);

        // saturation
        repeat (254) send(8'h42);
        chk("t6_err_fe", ERR_CNT, 8'hFE);
        repeat (46) send(8'h42);
        chk("t6_err_sat", ERR_CNT, 8'hFF);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
